// File: rtl/id_scoreboard_if.sv
// Signal bundle between the ID stage and the register-hazard scoreboard.
// The decoder side uses the master modport and the scoreboard uses the slave modport.
interface id_scoreboard_if #(
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int NSRC  = 2,
  parameter int SW    = 2
);
  logic                 issue_valid;
  logic                 issue_wr;
  logic [AW-1:0]        issue_dest;
  logic [SW-1:0]        issue_rdy;
  logic                 flush_id;
  logic [DEPTH-1:0]     flush_mask;
  logic                 pipe_hold;
  logic [NSRC-1:0]      src_valid;
  logic [NSRC*AW-1:0]   src_reg;
  logic                 ID_Stall;
  logic [NSRC*SW-1:0]   fwd_sel;
  logic                 busy;

  modport master (
    output issue_valid, issue_wr, issue_dest, issue_rdy, flush_id,
           flush_mask, pipe_hold, src_valid, src_reg,
    input  ID_Stall, fwd_sel, busy
  );

  modport slave (
    input  issue_valid, issue_wr, issue_dest, issue_rdy, flush_id,
           flush_mask, pipe_hold, src_valid, src_reg,
    output ID_Stall, fwd_sel, busy
  );
endinterface

// File: rtl/id_scoreboard.sv
// Register-hazard scoreboard: a shift pipeline of in-flight GPR writers, one
// slot per post-ID stage, driving the ID stall and per-source forward selects.
module id_scoreboard #(
  parameter int NREG  = 32,
  parameter int AW    = $clog2(NREG),
  parameter int DEPTH = 3,
  parameter int NSRC  = 2,
  parameter int SW    = $clog2(DEPTH + 1)
) (
  input logic            clock,
  input logic            reset_n,
  id_scoreboard_if.slave sb
);
  // Slot index i holds the writer currently in stage i+1.
  logic [DEPTH-1:0] validQ;
  logic [DEPTH-1:0] validNext;
  logic [AW-1:0]    destQ [DEPTH];
  logic [SW-1:0]    rdyQ  [DEPTH];

  logic [NSRC-1:0]  hazard;
  logic             stall;
  logic             insert;
  logic [SW-1:0]    issueRdy;

  for (genvar gi = 0; gi < NSRC; gi++) begin : gSrc
    logic [AW-1:0] srcReg;
    logic [SW-1:0] sel;
    logic          hz;

    assign srcReg = sb.src_reg[gi*AW +: AW];

    // Scan oldest to youngest so the youngest matching writer wins.
    always_comb begin
      sel = '0;
      hz  = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (sb.src_valid[gi] && (srcReg != '0) && validQ[i] && (destQ[i] == srcReg)) begin
          if ((i + 1) >= int'(rdyQ[i])) begin
            sel = SW'(i + 1);
            hz  = 1'b0;
          end else begin
            sel = '0;
            hz  = 1'b1;
          end
        end
      end
    end

    assign hazard[gi]                = hz;
    assign sb.fwd_sel[gi*SW +: SW]   = sel;
  end

  assign stall       = sb.pipe_hold | (|hazard);
  assign sb.ID_Stall = stall;
  assign sb.busy     = |validQ;

  assign insert   = sb.issue_valid & ~stall & ~sb.flush_id & sb.issue_wr & (sb.issue_dest != '0);
  assign issueRdy = (sb.issue_rdy == '0) ? SW'(1) : sb.issue_rdy;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : gStage
    if (gi == 0) begin : gHead
      assign validNext[gi] = sb.pipe_hold ? (validQ[gi] & ~sb.flush_mask[gi]) : insert;
    end else begin : gBody
      assign validNext[gi] = sb.pipe_hold ? (validQ[gi] & ~sb.flush_mask[gi])
                                          : (validQ[gi-1] & ~sb.flush_mask[gi-1]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      validQ <= '0;
    end else begin
      validQ <= validNext;
    end
  end

  // Payload needs no reset: it is only ever looked at through validQ.
  always_ff @(posedge clock) begin
    if (!sb.pipe_hold) begin
      destQ[0] <= sb.issue_dest;
      rdyQ[0]  <= issueRdy;
      for (int i = 1; i < DEPTH; i++) begin
        destQ[i] <= destQ[i-1];
        rdyQ[i]  <= rdyQ[i-1];
      end
    end
  end
endmodule
